prog_loader: RTL and testbench

- Debug program loader directly upstream of cpuCore.
- Accepts a byte stream (valid/ready) carrying a 16-bit word-count header followed by little-endian 32-bit instructions.
- Writes each instruction into cpuCore's instruction memory through the dbg_wr_en/dbg_addr/dbg_instr port.
- Holds the core in reset while loading and releases it once the whole image has been written.

---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/prog_loader_byte_packer.sv | 34 +++
 rtl/prog_loader.sv | 89 ++++++++
 tb/tb_prog_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the debug program loader.
package prog_loader_pkg;
  localparam int COUNT_W     = 16;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [3:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    SETUP,
    STROBE,
    HOLD,
    DONE,
    ERR
  } state_t;
endpackage

// File: rtl/prog_loader_byte_packer.sv
// Assembles INSTR_BYTES stream bytes into one little-endian instruction word.
import prog_loader_pkg::*;

module byte_packer #(
  parameter int W = 8 * INSTR_BYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [7:0]   byte_in,
  output logic [W-1:0] word,
  output logic         word_done
);
  localparam int IW = $clog2(INSTR_BYTES);
  localparam logic [IW-1:0] LAST = IW'(INSTR_BYTES - 1);

  logic [IW-1:0] idx;

  // Shifting in from the top leaves the first byte in bits [7:0].
  assign word_done = load && (idx == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
      idx  <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (load) begin
      word <= {byte_in, word[W-1:8]};
      idx  <= idx + 1'b1;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// Streams a word-count header plus instructions into cpuCore's instruction memory.
import prog_loader_pkg::*;

module prog_loader #(
  parameter int          XLEN      = 32,  // only 32 is supported
  parameter int unsigned BASE_ADDR = 4,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            byte_ready,
  output logic            dbg_wr_en,
  output logic [XLEN-1:0] dbg_addr,
  output logic [XLEN-1:0] dbg_instr,
  output logic            core_rst,
  output logic            busy,
  output logic            done,
  output logic            err
);
  state_t               state, nxt;
  logic [7:0]           cnt_lo;
  logic [COUNT_W-1:0]   count, idx, hdr_count;
  logic                 xfer, word_done, last_word, hdr_bad;

  assign xfer      = byte_valid && byte_ready;
  assign hdr_count = {byte_data, cnt_lo};
  assign hdr_bad   = (hdr_count == '0) || (hdr_count > COUNT_W'(MAX_WORDS));
  assign last_word = (idx == count - 1'b1);

  byte_packer #(.W(XLEN)) u_pack (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == HDR1 && xfer),
    .load      (state == DATA && xfer),
    .byte_in   (byte_data),
    .word      (dbg_instr),
    .word_done (word_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE, ERR: if (start) nxt = HDR0;
      HDR0:   if (xfer) nxt = HDR1;
      HDR1:   if (xfer) nxt = hdr_bad ? ERR : DATA;
      DATA:   if (word_done) nxt = SETUP;
      SETUP:  nxt = STROBE;
      STROBE: nxt = HOLD;
      HOLD:   nxt = last_word ? DONE : DATA;
      default: nxt = IDLE;
    endcase
  end

  // All handshake/status outputs decode from state so async reset clears them at once.
  assign byte_ready = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign dbg_wr_en  = (state == STROBE);
  assign core_rst   = (state != DONE);
  assign done       = (state == DONE);
  assign err        = (state == ERR);
  assign busy       = (state == HDR0) || (state == HDR1) || (state == DATA) ||
                      (state == SETUP) || (state == STROBE) || (state == HOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_lo   <= '0;
      count    <= '0;
      idx      <= '0;
      dbg_addr <= '0;
    end else begin
      if (state == HDR0 && xfer) cnt_lo <= byte_data;
      if (state == HDR1 && xfer) begin
        count <= hdr_count;
        idx   <= '0;
      end
      // Address latches with the last byte so it is settled throughout SETUP..HOLD.
      if (state == DATA && word_done)
        dbg_addr <= XLEN'(BASE_ADDR) + (XLEN'(idx) << 2);
      if (state == HOLD && !last_word) idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of images plus reset/reload sequences.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, dbg_wr_en, core_rst, busy, done, err;
  logic [31:0] dbg_addr, dbg_instr;

  int n_cmp = 0;
  int n_bad = 0;

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .dbg_wr_en(dbg_wr_en),
    .dbg_addr(dbg_addr), .dbg_instr(dbg_instr), .core_rst(core_rst),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: records every strobe and checks its surrounding cycles.
  logic [31:0] qa[$], qd[$];
  bit          mon_en = 1'b0;
  logic [31:0] prev_a, prev_d, held_a, held_d;
  logic        prev_rdy;
  bit          chk_after = 1'b0;

  initial begin
    prev_a = '0; prev_d = '0; prev_rdy = 1'b0; held_a = '0; held_d = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (chk_after) begin
          chk("wr_pulse_width", {31'b0, dbg_wr_en}, 32'd0);
          chk("addr_after", dbg_addr, held_a);
          chk("data_after", dbg_instr, held_d);
          chk("ready_hold", {31'b0, byte_ready}, 32'd0);
          chk_after = 1'b0;
        end
        if (dbg_wr_en) begin
          chk("addr_before", prev_a, dbg_addr);
          chk("data_before", prev_d, dbg_instr);
          chk("ready_setup", {31'b0, prev_rdy}, 32'd0);
          chk("ready_strobe", {31'b0, byte_ready}, 32'd0);
          qa.push_back(dbg_addr);
          qd.push_back(dbg_instr);
          held_a = dbg_addr; held_d = dbg_instr;
          chk_after = 1'b1;
        end
      end
      prev_a = dbg_addr; prev_d = dbg_instr; prev_rdy = byte_ready;
    end
  end

  typedef struct {
    logic [15:0]      cnt;
    int               nw;
    logic [2:0][31:0] w;
    logic [2:0][31:0] ea;
    bit               exp_err;
    int               stall_w;
    bit               ign;
  } vec_t;

  vec_t tbl[5];

  // Called just after a negedge; returns at the negedge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("byte_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    qa.delete(); qd.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d_hdr0_busy", id), {31'b0, busy}, 32'd1);
    chk($sformatf("v%0d_hdr0_ready", id), {31'b0, byte_ready}, 32'd1);
    chk($sformatf("v%0d_hdr0_core_rst", id), {31'b0, core_rst}, 32'd1);
    chk($sformatf("v%0d_hdr0_done_err", id), {30'b0, done, err}, 32'd0);
    send_byte(v.cnt[7:0]);
    send_byte(v.cnt[15:8]);
    if (v.exp_err) begin
      chk($sformatf("v%0d_err", id), {31'b0, err}, 32'd1);
      chk($sformatf("v%0d_err_core_rst", id), {31'b0, core_rst}, 32'd1);
      chk($sformatf("v%0d_err_ready", id), {31'b0, byte_ready}, 32'd0);
      chk($sformatf("v%0d_err_busy", id), {31'b0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_err_held", id), {31'b0, err}, 32'd1);
    end else begin
      for (int i = 0; i < v.nw; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (i == v.stall_w && k == 2) begin
            byte_valid = 1'b0;
            repeat (5) @(negedge clk);
            chk($sformatf("v%0d_stall_ready", id), {31'b0, byte_ready}, 32'd1);
            chk($sformatf("v%0d_stall_busy", id), {31'b0, busy}, 32'd1);
          end
          if (v.ign && i == 0 && k == 1) start = 1'b1;
          send_byte(v.w[i][8*k +: 8]);
          start = 1'b0;
        end
      end
      // Now in SETUP of the last word: STROBE, HOLD, then DONE.
      chk($sformatf("v%0d_setup_done", id), {31'b0, done}, 32'd0);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_hold_core_rst", id), {31'b0, core_rst}, 32'd1);
      chk($sformatf("v%0d_hold_done", id), {31'b0, done}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_done", id), {31'b0, done}, 32'd1);
      chk($sformatf("v%0d_run_core_rst", id), {31'b0, core_rst}, 32'd0);
      chk($sformatf("v%0d_run_busy", id), {31'b0, busy}, 32'd0);
    end
    chk($sformatf("v%0d_nwrites", id), qa.size(), v.nw);
    for (int i = 0; i < v.nw && i < qa.size(); i++) begin
      chk($sformatf("v%0d_w%0d_addr", id, i), qa[i], v.ea[i]);
      chk($sformatf("v%0d_w%0d_data", id, i), qd[i], v.w[i]);
    end
  endtask

  initial begin
    tbl[0] = '{16'd3, 3, {32'h0000DC63, 32'h00200113, 32'h00C00093},
               {32'd12, 32'd8, 32'd4}, 1'b0, -1, 1'b0};
    tbl[1] = '{16'h0000, 0, '0, '0, 1'b1, -1, 1'b0};
    tbl[2] = '{16'h0101, 0, '0, '0, 1'b1, -1, 1'b0};
    tbl[3] = '{16'd3, 3, {32'h0000DC63, 32'h00200113, 32'h00C00093},
               {32'd12, 32'd8, 32'd4}, 1'b0, 1, 1'b1};
    tbl[4] = '{16'd1, 1, {32'h0, 32'h0, 32'h00000013},
               {32'h0, 32'h0, 32'd4}, 1'b0, -1, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_core_rst", {31'b0, core_rst}, 32'd1);
    chk("rst_flags", {27'b0, byte_ready, dbg_wr_en, busy, done, err}, 32'd0);
    chk("rst_addr", dbg_addr, 32'd0);
    chk("rst_instr", dbg_instr, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'b0, byte_ready}, 32'd0);
    mon_en = 1'b1;

    for (int t = 0; t < 5; t++) run_vec(tbl[t], t);

    // Reset asserted while word 2 is being strobed.
    mon_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'd3); send_byte(8'd0);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) send_byte(tbl[0].w[i][8*k +: 8]);
    @(negedge clk);
    chk("mid_strobe_wr_en", {31'b0, dbg_wr_en}, 32'd1);
    chk("mid_strobe_addr", dbg_addr, 32'd8);
    rst = 1'b0;
    #1;
    chk("arst_wr_en", {31'b0, dbg_wr_en}, 32'd0);
    chk("arst_core_rst", {31'b0, core_rst}, 32'd1);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_addr", dbg_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {29'b0, busy, done, err}, 32'd0);
    mon_en = 1'b1;
    run_vec(tbl[4], 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
